// File: rtl/dircc_router_pkg.sv
// Shared definitions for the directional router: channel encodings, the
// broadcast address constant, the packet FSM states and the route decoder.
package dircc_router_pkg;

   // Output channel encodings.
   typedef enum logic [1:0] {
      CH_LOCAL = 2'd0,
      CH_UP    = 2'd1,
      CH_DOWN  = 2'd2,
      CH_BCAST = 2'd3
   } channel_t;

   // Packet tracking states.
   typedef enum logic {
      ST_IDLE      = 1'b0,
      ST_IN_PACKET = 1'b1
   } state_t;

   // Widest supported address; the broadcast address is all-ones at the
   // actual address width, derived from this by shifting.
   localparam int unsigned MAX_ADDR_WIDTH = 64;
   localparam logic [MAX_ADDR_WIDTH-1:0] BCAST_ADDR = '1;

   // Decode a destination against this node's address. Both operands are
   // zero-extended to MAX_ADDR_WIDTH; addr_w is the real address width.
   function automatic channel_t route_decode(
      input logic [MAX_ADDR_WIDTH-1:0] dest,
      input logic [MAX_ADDR_WIDTH-1:0] addr,
      input int unsigned               addr_w
   );
      logic [MAX_ADDR_WIDTH-1:0] bcast;
      bcast = BCAST_ADDR >> (MAX_ADDR_WIDTH - addr_w);
      if (dest == bcast)     return CH_BCAST;
      else if (dest == addr) return CH_LOCAL;
      else if (dest > addr)  return CH_UP;
      else                   return CH_DOWN;
   endfunction

endpackage

// File: rtl/dircc_router.sv
// Directional packet router: decodes the destination from the header beat,
// tags every beat of the packet with the chosen output channel and forwards
// the stream through a single output register stage.
//
// Handshake: a beat moves on an interface at a rising edge where valid and
// ready are both high. in_ready = !out_valid || out_ready (and low during
// reset); out_valid is purely registered and never follows in_valid
// combinationally; out_* hold steady while out_valid && !out_ready.
module dircc_router
   import dircc_router_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int EMPTY_WIDTH   = 2,
   parameter int ADDR_WIDTH    = 16,
   parameter int CHANNEL_WIDTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDR_WIDTH-1:0]    address,
   output logic                     in_ready,
   input  logic                     in_valid,
   input  logic [DATA_WIDTH-1:0]    in_data,
   input  logic                     in_startofpacket,
   input  logic                     in_endofpacket,
   input  logic [EMPTY_WIDTH-1:0]   in_empty,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic [CHANNEL_WIDTH-1:0] out_channel,
   output logic                     out_startofpacket,
   output logic                     out_endofpacket,
   output logic [EMPTY_WIDTH-1:0]   out_empty
);

   state_t                   state;
   state_t                   state_next;
   logic [CHANNEL_WIDTH-1:0] pkt_channel;
   logic [CHANNEL_WIDTH-1:0] beat_channel;
   logic [ADDR_WIDTH-1:0]    dest;
   logic                     accept;
   logic                     forward;

   assign in_ready = !reset && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign dest     = in_data[DATA_WIDTH-1 -: ADDR_WIDTH];
   // Only beats belonging to a packet are forwarded; stray beats in IDLE
   // are accepted and dropped.
   assign forward  = accept && (in_startofpacket || state == ST_IN_PACKET);

   // Header beats use a fresh decode (address sampled now); other beats
   // reuse the channel latched at the header.
   always_comb begin
      beat_channel = pkt_channel;
      if (in_startofpacket) begin
         beat_channel = CHANNEL_WIDTH'(route_decode(64'(dest), 64'(address), ADDR_WIDTH));
      end
   end

   // Next-state logic: SOP always (re)starts a packet, EOP always ends it.
   always_comb begin
      state_next = state;
      if (accept) begin
         if (in_startofpacket) begin
            state_next = in_endofpacket ? ST_IDLE : ST_IN_PACKET;
         end else if (state == ST_IN_PACKET && in_endofpacket) begin
            state_next = ST_IDLE;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Latch the decoded channel at each accepted header.
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_channel <= '0;
      end else if (accept && in_startofpacket) begin
         pkt_channel <= beat_channel;
      end
   end

   // Output register stage; loads only when the stage is free or draining.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid         <= 1'b0;
         out_data          <= '0;
         out_channel       <= '0;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
         out_empty         <= '0;
      end else if (in_ready) begin
         out_valid <= forward;
         if (forward) begin
            out_data          <= in_data;
            out_channel       <= beat_channel;
            out_startofpacket <= in_startofpacket;
            out_endofpacket   <= in_endofpacket;
            out_empty         <= in_empty;
         end
      end
   end

endmodule

// File: tb/tb_dircc_router.sv
// Scoreboard bench for dircc_router: the driver pushes hand-computed
// expected beats, a negedge monitor pops and compares every output transfer.
module tb_dircc_router;

   localparam int DW = 32;
   localparam int EW = 2;
   localparam int AW = 16;
   localparam int CW = 2;
   // Packed expected beat: {data, channel, sop, eop, empty}
   localparam int W  = DW + CW + 1 + 1 + EW;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] address;
   logic          in_ready;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_startofpacket;
   logic          in_endofpacket;
   logic [EW-1:0] in_empty;
   logic          out_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_channel;
   logic          out_startofpacket;
   logic          out_endofpacket;
   logic [EW-1:0] out_empty;

   logic [W-1:0] exp_q[$];
   int           pop_cyc[$];
   int           checks   = 0;
   int           failures = 0;
   int           cycle    = 0;

   dircc_router #(
      .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .ADDR_WIDTH(AW), .CHANNEL_WIDTH(CW)
   ) dut (
      .clk(clk), .reset(reset), .address(address),
      .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
      .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
      .in_empty(in_empty), .out_ready(out_ready), .out_valid(out_valid),
      .out_data(out_data), .out_channel(out_channel),
      .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
      .out_empty(out_empty)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   // Generic comparison helper
   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Monitor: every output transfer is compared against the queue head
   always @(negedge clk) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         logic [W-1:0] got;
         got = {out_data, out_channel, out_startofpacket, out_endofpacket, out_empty};
         checks++;
         pop_cyc.push_back(cycle);
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat got=%0h exp=none", got);
         end else begin
            logic [W-1:0] exp;
            exp = exp_q.pop_front();
            if (got !== exp) begin
               failures++;
               $display("FAIL beat got=%0h exp=%0h", got, exp);
            end
         end
      end
   end

   // Driver: present one beat, wait (bounded) for acceptance. If fwd is set
   // the expected output beat with channel ch is queued.
   task automatic send(input logic [DW-1:0] d, input logic sop, input logic eop,
                       input logic [EW-1:0] emp, input logic fwd, input logic [CW-1:0] ch);
      int n;
      in_data          = d;
      in_startofpacket = sop;
      in_endofpacket   = eop;
      in_empty         = emp;
      in_valid         = 1'b1;
      if (fwd) exp_q.push_back({d, ch, sop, eop, emp});
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 50) begin
         failures++;
         $display("FAIL send_timeout got=in_ready_low exp=accept");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      reset = 1'b1; address = 16'h0005; in_valid = 1'b0; in_data = '0;
      in_startofpacket = 1'b0; in_endofpacket = 1'b0; in_empty = '0; out_ready = 1'b1;
      idle(2);
      check("reset_in_ready", 64'(in_ready), 64'd0);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out_data", 64'(out_data), 64'd0);
      check("reset_out_channel", 64'(out_channel), 64'd0);
      reset = 1'b0;
      idle(1);
      check("in_ready_after_reset", 64'(in_ready), 64'd1);

      // Routing decisions, single-beat packets
      send(32'h0005_0000, 1, 1, 2'd0, 1, 2'd0);
      send(32'h0009_0000, 1, 1, 2'd0, 1, 2'd1);
      send(32'h0002_0000, 1, 1, 2'd0, 1, 2'd2);
      send(32'hFFFF_0000, 1, 1, 2'd0, 1, 2'd3);
      idle(2);

      // Channel hold across a 3-beat packet (last beat would decode as down)
      send(32'h0009_1234, 1, 0, 2'd0, 1, 2'd1);
      send(32'hAAAA_AAAA, 0, 0, 2'd0, 1, 2'd1);
      send(32'h0001_0000, 0, 1, 2'd2, 1, 2'd1);
      idle(2);

      // Address change mid-packet does not affect the packet in flight
      send(32'h0009_0000, 1, 0, 2'd0, 1, 2'd1);
      address = 16'h000A;
      send(32'h0009_0001, 0, 1, 2'd1, 1, 2'd1);
      send(32'h0009_0002, 1, 1, 2'd3, 1, 2'd2);
      address = 16'h0005;
      idle(2);

      // Backpressure: one beat held for three cycles, a second one waiting
      out_ready = 1'b0;
      send(32'h0005_00A1, 1, 0, 2'd0, 1, 2'd0);
      in_data = 32'h0000_00B2; in_startofpacket = 1'b0; in_endofpacket = 1'b1;
      in_empty = 2'd1; in_valid = 1'b1;
      exp_q.push_back({32'h0000_00B2, 2'd0, 1'b0, 1'b1, 2'd1});
      for (int i = 0; i < 3; i++) begin
         idle(1);
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_out_data", 64'(out_data), 64'h0005_00A1);
         check("bp_out_sop", 64'(out_startofpacket), 64'd1);
         check("bp_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      idle(1);
      in_valid = 1'b0;
      idle(2);
      check("bp_drained", 64'(exp_q.size()), 64'd0);

      // Streaming: 8 back-to-back beats, 8 consecutive output cycles
      pop_cyc.delete();
      for (int i = 0; i < 8; i++) begin
         send(32'hFFFF_0000 + 32'(i), (i == 0), (i == 7), 2'd0, 1, 2'd3);
      end
      idle(2);
      check("stream_count", 64'(pop_cyc.size()), 64'd8);
      if (pop_cyc.size() == 8) begin
         for (int i = 1; i < 8; i++) begin
            check("stream_consecutive", 64'(pop_cyc[i] - pop_cyc[0]), 64'(i));
         end
      end

      // Stray beat in IDLE is dropped; SOP mid-packet restarts routing
      send(32'h0003_0000, 0, 0, 2'd0, 0, 2'd0);
      idle(2);
      check("stray_no_output", 64'(out_valid), 64'd0);
      send(32'h0009_0000, 1, 0, 2'd0, 1, 2'd1);
      send(32'h1111_1111, 0, 0, 2'd0, 1, 2'd1);
      send(32'h0002_0000, 1, 0, 2'd0, 1, 2'd2);
      send(32'h0009_0000, 0, 0, 2'd0, 1, 2'd2);
      send(32'h2222_2222, 0, 1, 2'd0, 1, 2'd2);
      idle(2);

      // Reset mid-packet: the remainder of the packet is dropped
      send(32'h0009_0000, 1, 0, 2'd0, 1, 2'd1);
      send(32'h3333_3333, 0, 0, 2'd0, 1, 2'd1);
      reset = 1'b1;
      idle(1);
      check("rst_mid_out_valid", 64'(out_valid), 64'd0);
      check("rst_mid_in_ready", 64'(in_ready), 64'd0);
      reset = 1'b0;
      send(32'h4444_4444, 0, 0, 2'd0, 0, 2'd0);
      send(32'h5555_5555, 0, 1, 2'd0, 0, 2'd0);
      idle(3);
      check("rst_mid_no_output", 64'(out_valid), 64'd0);

      // Routing still works after the mid-packet reset
      send(32'h0004_0000, 1, 1, 2'd0, 1, 2'd2);
      idle(3);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
